// File: rtl/buzzer_req_if.sv
// Request/tick bundle between the event sources and the buzzer request controller.
// The master drives requests and clears; the slave returns tick, start and status.
interface buzzer_req_if #(
   parameter int NSRC   = 4,
   parameter int PEND_W = 3
);
   logic [NSRC-1:0]   i_evt;
   logic              i_flush;
   logic              i_ovf_clr;
   logic              o_pls_1k;
   logic              o_go;
   logic              o_busy;
   logic [PEND_W-1:0] o_pend;
   logic              o_ovf;

   modport master (
      output i_evt, i_flush, i_ovf_clr,
      input  o_pls_1k, o_go, o_busy, o_pend, o_ovf
   );

   modport slave (
      input  i_evt, i_flush, i_ovf_clr,
      output o_pls_1k, o_go, o_busy, o_pend, o_ovf
   );
endinterface

// File: rtl/buzzer_req_ctrl.sv
// Tick prescaler plus request queue that spaces buzzer start pulses
// by a guard window of GUARD_MS ticks.
module buzzer_req_ctrl #(
   parameter int CLK_HZ   = 100_000_000,
   parameter int TICK_HZ  = 1000,
   parameter int GUARD_MS = 260,
   parameter int NSRC     = 4,
   parameter int PEND_W   = 3
) (
   input logic         i_clk,
   input logic         i_rst,
   buzzer_req_if.slave bus
);
   localparam int DIV  = CLK_HZ / TICK_HZ;
   localparam int DW   = $clog2(DIV);
   localparam int GW   = $clog2(GUARD_MS + 1);
   localparam int PMAX = (2 ** PEND_W) - 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FIRE  = 2'd1,
      GUARD = 2'd2
   } state_e;

   state_e            state_q;
   logic              go_q;
   logic              busy_q;
   logic [GW-1:0]     gcnt_q;

   logic [DW-1:0]     pre_q, pre_d;
   logic              pls_q, pls_d;
   logic [NSRC-1:0]   evt_d_q, evt_d_d;
   logic [NSRC-1:0]   rise;
   logic [PEND_W-1:0] pend_q, pend_d;
   logic              ovf_q, ovf_d;
   int                inc;
   int                sum;

   always_comb begin
      pre_d   = (pre_q == DW'(DIV - 1)) ? '0 : pre_q + 1'b1;
      pls_d   = (pre_q == DW'(DIV - 1));
      evt_d_d = bus.i_evt;
      rise    = bus.i_evt & ~evt_d_q;
      inc     = 0;
      for (int i = 0; i < NSRC; i++) begin
         inc = inc + int'(rise[i]);
      end
      sum = int'(pend_q) + inc - ((state_q == FIRE) ? 1 : 0);
      pend_d = pend_q;
      ovf_d  = ovf_q;
      if (bus.i_flush) begin
         pend_d = '0;
      end else if (sum > PMAX) begin
         pend_d = PEND_W'(PMAX);
      end else if (sum < 0) begin
         pend_d = '0;
      end else begin
         pend_d = PEND_W'(sum);
      end
      // a drop at saturation beats a same-cycle clear
      if (!bus.i_flush && sum > PMAX) begin
         ovf_d = 1'b1;
      end else if (bus.i_ovf_clr) begin
         ovf_d = 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         pre_q   <= '0;
         pls_q   <= 1'b0;
         evt_d_q <= '1;
         pend_q  <= '0;
         ovf_q   <= 1'b0;
      end else begin
         pre_q   <= pre_d;
         pls_q   <= pls_d;
         evt_d_q <= evt_d_d;
         pend_q  <= pend_d;
         ovf_q   <= ovf_d;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= IDLE;
         go_q    <= 1'b0;
         busy_q  <= 1'b0;
         gcnt_q  <= '0;
      end else begin
         go_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (pend_q != '0) begin
                  state_q <= FIRE;
                  go_q    <= 1'b1;
                  busy_q  <= 1'b1;
               end
            end
            FIRE: begin
               state_q <= GUARD;
               gcnt_q  <= '0;
            end
            GUARD: begin
               if (pls_q) begin
                  if (gcnt_q == GW'(GUARD_MS - 1)) begin
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                  end else begin
                     gcnt_q <= gcnt_q + 1'b1;
                  end
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.o_pls_1k = pls_q;
   assign bus.o_go     = go_q;
   assign bus.o_busy   = busy_q;
   assign bus.o_pend   = pend_q;
   assign bus.o_ovf    = ovf_q;
endmodule

// File: tb/tb_buzzer_req_ctrl.sv
// Directed bench for buzzer_req_ctrl: per-cycle check against a
// tick/queue model plus literal expectations at key cycles.
module tb_buzzer_req_ctrl;
   localparam int DIV   = 10;
   localparam int GUARD = 3;
   localparam int NSRC  = 4;
   localparam int PW    = 3;
   localparam int PMAX  = 7;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0;
   int   fails = 0;

   buzzer_req_if #(.NSRC(NSRC), .PEND_W(PW)) bus ();

   buzzer_req_ctrl #(
      .CLK_HZ(20), .TICK_HZ(2), .GUARD_MS(GUARD),
      .NSRC(NSRC), .PEND_W(PW)
   ) dut (
      .i_clk(clk),
      .i_rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   // model state describes the cycle after the latest rising edge
   int        m_cyc   = 0;
   int        m_pend  = 0;
   bit        m_ovf   = 0;
   bit        m_go    = 0;
   bit        m_busy  = 0;
   int        m_ticks = 0;
   bit        m_valid = 0;
   logic [NSRC-1:0] m_prev = '1;

   function automatic bit tick_at(int c);
      return (c > 0) && (c % DIV == 0);
   endfunction

   always @(posedge clk) begin
      int rises;
      int v;
      bit n_go;
      bit n_busy;
      if (rst) begin
         m_cyc = 0; m_pend = 0; m_ovf = 0; m_go = 0;
         m_busy = 0; m_ticks = 0; m_prev = '1; m_valid = 1;
      end else begin
         rises = 0;
         for (int i = 0; i < NSRC; i++)
            if (bus.i_evt[i] && !m_prev[i]) rises++;
         m_prev = bus.i_evt;
         n_go = 0;
         n_busy = m_busy;
         if (m_go) m_ticks = 0;
         else if (m_busy && tick_at(m_cyc)) begin
            m_ticks++;
            if (m_ticks == GUARD) n_busy = 0;
         end
         if (!m_busy && m_pend > 0) begin
            n_go = 1;
            n_busy = 1;
         end
         if (bus.i_flush) begin
            v = 0;
            if (bus.i_ovf_clr) m_ovf = 0;
         end else begin
            v = m_pend + rises - (m_go ? 1 : 0);
            if (v > PMAX) begin
               v = PMAX;
               m_ovf = 1;
            end else if (bus.i_ovf_clr) m_ovf = 0;
            if (v < 0) v = 0;
         end
         m_pend = v;
         m_go = n_go;
         m_busy = n_busy;
         m_cyc++;
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         tests++;
         if (bus.o_pls_1k !== tick_at(m_cyc) || bus.o_go !== m_go ||
             bus.o_busy !== m_busy || bus.o_pend !== PW'(m_pend) ||
             bus.o_ovf !== m_ovf) begin
            fails++;
            $display("FAIL model cyc=%0d got pls=%b go=%b busy=%b pend=%0d ovf=%b exp pls=%b go=%b busy=%b pend=%0d ovf=%b",
               m_cyc, bus.o_pls_1k, bus.o_go, bus.o_busy, bus.o_pend, bus.o_ovf,
               tick_at(m_cyc), m_go, m_busy, m_pend, m_ovf);
         end
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s got %0d exp %0d", nm, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_idle(input string nm);
      int k;
      k = 0;
      while (bus.o_busy && k < 100) begin
         step(1);
         k++;
      end
      chk(nm, int'(bus.o_busy), 0);
   endtask

   initial begin
      int n;
      int last;
      bus.i_evt = '0;
      bus.i_flush = 0;
      bus.i_ovf_clr = 0;
      step(3);
      rst = 0;
      chk("rst_go", int'(bus.o_go), 0);
      chk("rst_busy", int'(bus.o_busy), 0);
      chk("rst_pend", int'(bus.o_pend), 0);
      chk("rst_pls", int'(bus.o_pls_1k), 0);
      step(5);
      bus.i_evt = 4'b0001;
      step(1);
      chk("t2_pend_c6", int'(bus.o_pend), 1);
      chk("t2_nogo_c6", int'(bus.o_go), 0);
      step(1);
      chk("t2_go_c7", int'(bus.o_go), 1);
      chk("t2_busy_c7", int'(bus.o_busy), 1);
      step(1);
      chk("t2_pend_c8", int'(bus.o_pend), 0);
      step(1);
      chk("t1_pls_c9", int'(bus.o_pls_1k), 0);
      step(1);
      chk("t1_pls_c10", int'(bus.o_pls_1k), 1);
      step(20);
      chk("t2_busy_c30", int'(bus.o_busy), 1);
      step(1);
      chk("t2_idle_c31", int'(bus.o_busy), 0);

      bus.i_evt = '0;
      step(2);
      bus.i_evt = 4'b1111;
      step(1);
      chk("t3_pend4", int'(bus.o_pend), 4);
      n = 0;
      last = 0;
      for (int k = 0; k < 250 && n < 4; k++) begin
         step(1);
         if (bus.o_go) begin
            if (n > 0) begin
               tests++;
               if (m_cyc - last < 20 || m_cyc - last > 40) begin
                  fails++;
                  $display("FAIL t3_spacing got %0d exp 20..40", m_cyc - last);
               end
            end
            last = m_cyc;
            n++;
         end
      end
      chk("t3_go_count", n, 4);
      wait_idle("t3_idle");
      chk("t3_pend_end", int'(bus.o_pend), 0);

      bus.i_evt = '0;
      step(1);
      bus.i_evt = 4'b0010;
      step(3);
      chk("t4_guard", int'(bus.o_busy), 1);
      for (int k = 0; k < 8; k++) begin
         bus.i_evt[2] = 1'b1;
         step(1);
         bus.i_evt[2] = 1'b0;
         step(1);
      end
      chk("t4_pend_sat", int'(bus.o_pend), 7);
      chk("t4_ovf", int'(bus.o_ovf), 1);
      bus.i_ovf_clr = 1;
      step(1);
      bus.i_ovf_clr = 0;
      chk("t4_ovf_clr", int'(bus.o_ovf), 0);
      bus.i_flush = 1;
      step(1);
      bus.i_flush = 0;
      chk("t4_flush", int'(bus.o_pend), 0);
      wait_idle("t4_idle");

      bus.i_evt = 4'b1000;
      step(3);
      chk("t5_guard", int'(bus.o_busy), 1);
      for (int k = 0; k < 3; k++) begin
         bus.i_evt[2] = 1'b1;
         step(1);
         bus.i_evt[2] = 1'b0;
         step(1);
      end
      chk("t5_pend3", int'(bus.o_pend), 3);
      bus.i_flush = 1;
      step(1);
      bus.i_flush = 0;
      chk("t5_flush", int'(bus.o_pend), 0);
      wait_idle("t5_idle");
      n = 0;
      for (int k = 0; k < 50; k++) begin
         step(1);
         if (bus.o_go) n++;
      end
      chk("t5_no_go", n, 0);

      rst = 1;
      bus.i_evt = 4'b1111;
      step(2);
      rst = 0;
      step(5);
      chk("t6_held_pend", int'(bus.o_pend), 0);
      chk("t6_held_busy", int'(bus.o_busy), 0);
      bus.i_evt[0] = 1'b0;
      step(1);
      bus.i_evt[0] = 1'b1;
      step(3);
      chk("t6_guard", int'(bus.o_busy), 1);
      rst = 1;
      step(1);
      rst = 0;
      chk("t6_rst_busy", int'(bus.o_busy), 0);
      chk("t6_rst_go", int'(bus.o_go), 0);
      chk("t6_rst_pend", int'(bus.o_pend), 0);
      step(5);
      chk("t6_after_busy", int'(bus.o_busy), 0);
      step(2);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end
endmodule
